// File: rtl/bridge_pkg.sv
// Shared definitions for the bridge forwarding path: scheduler state encoding,
// frame header size, port identifiers and the default forwarding length limit.
package bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        CHECK,
        EMIT_HI,
        EMIT_LO,
        FWD,
        DROP
    } arb_state_e;

    localparam int   HDR_BYTES       = 2;
    localparam logic PORT0           = 1'b0;
    localparam logic PORT1           = 1'b1;
    localparam int   DEFAULT_MAX_LEN = 1518;

endpackage

// File: rtl/bridge_fwd_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational from the
// requests; the last-served port is committed only when the owner reports done.
module rr_arb2
    import bridge_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       served,
    output logic       gnt
);

    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (done) begin
            last_d = served;
        end
    end

    // Last-served starts at port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        gnt = PORT0;
        if (req == 2'b11) begin
            gnt = ~last_q;
        end else if (req == 2'b10) begin
            gnt = PORT1;
        end
    end

endmodule

// File: rtl/bridge_fwd_arbiter.sv
// Frame-granular forwarding scheduler from two ingress FIFOs into one egress FIFO.
// Optional statistics counters are built only when BRIDGE_ARB_STATS_EN is defined.
module bridge_fwd_arbiter
    import bridge_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int LEN_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in0_data,
    input  logic        in0_empty,
    output logic        in0_read,
    input  logic [7:0]  in1_data,
    input  logic        in1_empty,
    output logic        in1_read,
    output logic [7:0]  out_data,
    output logic        out_write,
    input  logic        out_full,
    output logic        grant,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_drop,
    output logic [15:0] fwd_cnt0,
    output logic [15:0] fwd_cnt1,
    output logic [15:0] drop_cnt
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

    arb_state_e       state_q, state_d;
    logic             grant_q, grant_d;
    logic [LEN_W-1:0] len_q, len_d, rem_q, rem_d;
    logic             infl_q, infl_d, hold_v_q, hold_v_d;
    logic [7:0]       hold_q, hold_d;
    logic             done_q, done_d, drop_q, drop_d;
    logic             rd, rd_port, arb_gnt, src_empty;
    logic [7:0]       src_data;

    assign src_empty = (grant_q == PORT1) ? in1_empty : in0_empty;
    assign src_data  = (grant_q == PORT1) ? in1_data  : in0_data;

    rr_arb2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({~in1_empty, ~in0_empty}),
        .done   (done_d | drop_d),
        .served (grant_q),
        .gnt    (arb_gnt)
    );

    // infl_q marks a read issued last cycle whose byte is on src_data now.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        len_d     = len_q;
        rem_d     = rem_q;
        infl_d    = 1'b0;
        hold_v_d  = hold_v_q;
        hold_d    = hold_q;
        done_d    = 1'b0;
        drop_d    = 1'b0;
        rd        = 1'b0;
        rd_port   = grant_q;
        out_write = 1'b0;
        out_data  = 8'h00;
        case (state_q)
            IDLE: begin
                if (rst_n && (!in0_empty || !in1_empty)) begin
                    rd      = 1'b1;
                    rd_port = arb_gnt;
                    grant_d = arb_gnt;
                    infl_d  = 1'b1;
                    state_d = HDR_HI;
                end
            end
            HDR_HI: begin
                if (infl_q) begin
                    len_d = LEN_W'(src_data);
                end
                if (!src_empty) begin
                    rd      = 1'b1;
                    infl_d  = 1'b1;
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                len_d   = (len_q << 8) | LEN_W'(src_data);
                state_d = CHECK;
            end
            CHECK: begin
                rem_d   = len_q;
                state_d = (len_q > MAX_LEN_L) ? DROP : EMIT_HI;
            end
            EMIT_HI: begin
                if (!out_full) begin
                    out_write = 1'b1;
                    out_data  = 8'(len_q >> 8);
                    state_d   = EMIT_LO;
                end
            end
            EMIT_LO: begin
                if (!out_full) begin
                    out_write = 1'b1;
                    out_data  = len_q[7:0];
                    if (len_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = FWD;
                    end
                end
            end
            FWD: begin
                // A parked byte always drains before a freshly returned one.
                if (hold_v_q) begin
                    if (!out_full) begin
                        out_write = 1'b1;
                        out_data  = hold_q;
                        hold_v_d  = 1'b0;
                    end
                end else if (infl_q) begin
                    if (!out_full) begin
                        out_write = 1'b1;
                        out_data  = src_data;
                    end else begin
                        hold_v_d = 1'b1;
                        hold_d   = src_data;
                    end
                end
                if (out_write) begin
                    rem_d = rem_q - ONE;
                    if (rem_q == ONE) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                if (!src_empty && !hold_v_q && !(infl_q && out_full) &&
                    (rem_q > LEN_W'(infl_q))) begin
                    rd     = 1'b1;
                    infl_d = 1'b1;
                end
            end
            DROP: begin
                if (!src_empty) begin
                    rd    = 1'b1;
                    rem_d = rem_q - ONE;
                    if (rem_q == ONE) begin
                        drop_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= PORT0;
            len_q    <= '0;
            rem_q    <= '0;
            infl_q   <= 1'b0;
            hold_v_q <= 1'b0;
            hold_q   <= 8'h00;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            infl_q   <= infl_d;
            hold_v_q <= hold_v_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
        end
    end

    assign in0_read   = rd && (rd_port == PORT0);
    assign in1_read   = rd && (rd_port == PORT1);
    assign grant      = grant_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;
    assign frame_drop = drop_q;

`ifdef BRIDGE_ARB_STATS_EN
    logic [15:0] fwd_cnt0_q, fwd_cnt0_d, fwd_cnt1_q, fwd_cnt1_d, drop_cnt_q, drop_cnt_d;

    always_comb begin
        fwd_cnt0_d = fwd_cnt0_q;
        fwd_cnt1_d = fwd_cnt1_q;
        drop_cnt_d = drop_cnt_q;
        if (done_d && (grant_q == PORT0) && (fwd_cnt0_q != 16'hFFFF)) begin
            fwd_cnt0_d = fwd_cnt0_q + 16'd1;
        end
        if (done_d && (grant_q == PORT1) && (fwd_cnt1_q != 16'hFFFF)) begin
            fwd_cnt1_d = fwd_cnt1_q + 16'd1;
        end
        if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cnt0_q <= 16'h0000;
            fwd_cnt1_q <= 16'h0000;
            drop_cnt_q <= 16'h0000;
        end else begin
            fwd_cnt0_q <= fwd_cnt0_d;
            fwd_cnt1_q <= fwd_cnt1_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign fwd_cnt0 = fwd_cnt0_q;
    assign fwd_cnt1 = fwd_cnt1_q;
    assign drop_cnt = drop_cnt_q;
`else
    assign fwd_cnt0 = 16'h0000;
    assign fwd_cnt1 = 16'h0000;
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_bridge_fwd_arbiter.sv
// Bench for bridge_fwd_arbiter: byte-queue ingress FIFO models, an egress
// scoreboard fed by a frame-level round-robin reference model, directed and random steps.
module tb_bridge_fwd_arbiter;

    localparam int MAX_LEN = 1518;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in0_data = 8'h00;
    logic [7:0]  in1_data = 8'h00;
    logic        in0_empty = 1'b1;
    logic        in1_empty = 1'b1;
    logic        in0_read, in1_read;
    logic [7:0]  out_data;
    logic        out_write;
    logic        out_full = 1'b0;
    logic        grant, busy, frame_done, frame_drop;
    logic [15:0] fwd_cnt0, fwd_cnt1, drop_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int ev_cnt = 0;
    int last_ev_cyc = 0;
    logic [31:0] mon_exp;

    logic [7:0] q0[$], q1[$];
    logic [7:0] m0[$], m1[$];
    int         lens0[$], lens1[$];
    logic [7:0] exp_q[$];
    logic [2:0] exp_ev_q[$];
    int         wr_cyc_q[$];
    int         m_last = 1;
    int         e_fwd0 = 0, e_fwd1 = 0, e_drop = 0;
    bit         bp_rand = 0;

    bridge_fwd_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in0_data   (in0_data),
        .in0_empty  (in0_empty),
        .in0_read   (in0_read),
        .in1_data   (in1_data),
        .in1_empty  (in1_empty),
        .in1_read   (in1_read),
        .out_data   (out_data),
        .out_write  (out_write),
        .out_full   (out_full),
        .grant      (grant),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_drop (frame_drop),
        .fwd_cnt0   (fwd_cnt0),
        .fwd_cnt1   (fwd_cnt1),
        .drop_cnt   (drop_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] stat(input int v);
`ifdef BRIDGE_ARB_STATS_EN
        return 16'(v);
`else
        return 16'(v * 0);
`endif
    endfunction

    // Ingress FIFO models: one-cycle read latency, empty reflects post-pop contents.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in0_read) begin
            chk("rd0_nonempty", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) in0_data <= q0.pop_front();
        end
        if (in1_read) begin
            chk("rd1_nonempty", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) in1_data <= q1.pop_front();
        end
        in0_empty <= (q0.size() == 0);
        in1_empty <= (q1.size() == 0);
    end

    // Egress scoreboard and frame-event scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_write) begin
                chk("wr_while_full", 32'(out_full), 32'd0);
                mon_exp = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
                chk("egress_byte", 32'(out_data), mon_exp);
                wr_cyc_q.push_back(cyc);
                wr_cnt++;
            end
            if (frame_done || frame_drop) begin
                mon_exp = (exp_ev_q.size() != 0) ? 32'(exp_ev_q.pop_front()) : 32'hDEAD_BEEF;
                chk("frame_event", 32'({grant, frame_drop, frame_done}), mon_exp);
                ev_cnt++;
                last_ev_cyc = cyc;
            end
        end
    end

    task automatic load_frame(input int port, input int len, input bit pat);
        logic [7:0] b;
        for (int i = 0; i < len + 2; i++) begin
            if (i == 0) b = 8'(len >> 8);
            else if (i == 1) b = 8'(len);
            else if (pat) b = 8'(8'hAA + 8'h11 * (i - 2));
            else b = 8'($urandom_range(0, 255));
            if (port == 0) begin q0.push_back(b); m0.push_back(b); end
            else begin q1.push_back(b); m1.push_back(b); end
        end
        if (port == 0) lens0.push_back(len);
        else lens1.push_back(len);
    endtask

    // Reference: whole frames served alternately when both ports hold frames.
    task automatic model_batch();
        int p;
        int len;
        logic [7:0] b;
        while (lens0.size() != 0 || lens1.size() != 0) begin
            if (lens0.size() != 0 && lens1.size() != 0) p = (m_last == 1) ? 0 : 1;
            else p = (lens0.size() != 0) ? 0 : 1;
            len = (p == 1) ? lens1.pop_front() : lens0.pop_front();
            for (int i = 0; i < len + 2; i++) begin
                b = (p == 1) ? m1.pop_front() : m0.pop_front();
                if (len <= MAX_LEN) exp_q.push_back(b);
            end
            if (len <= MAX_LEN) begin
                exp_ev_q.push_back({p[0], 2'b01});
                if (p == 0) e_fwd0++; else e_fwd1++;
            end else begin
                exp_ev_q.push_back({p[0], 2'b10});
                e_drop++;
            end
            m_last = p;
        end
    endtask

    int batch_n = 0;

    task automatic start_batch();
        wr_cnt = 0;
        ev_cnt = 0;
        wr_cyc_q.delete();
        batch_n = lens0.size() + lens1.size();
        model_batch();
    endtask

    task automatic finish_batch(input string tag, input int budget);
        int k;
        k = 0;
        while (ev_cnt < batch_n && k < budget) begin
            @(posedge clk); #1;
            if (bp_rand) out_full = ($urandom_range(0, 3) == 0);
            k++;
        end
        out_full = 1'b0;
        chk({tag, "_events"}, ev_cnt, batch_n);
        repeat (3) begin @(posedge clk); #1; end
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_fwd_cnt0"}, 32'(fwd_cnt0), 32'(stat(e_fwd0)));
        chk({tag, "_fwd_cnt1"}, 32'(fwd_cnt1), 32'(stat(e_fwd1)));
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(stat(e_drop)));
    endtask

    initial begin
        int c0;
        int k;
        int w0;
        int n0;
        int n1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {in0_read, in1_read, out_write, grant, busy, frame_done, frame_drop},
            7'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_counters", {fwd_cnt0, fwd_cnt1}, 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Three-byte frame on port 0 with timing landmarks.
        load_frame(0, 3, 1'b1);
        start_batch();
        @(posedge clk);
        @(negedge clk);
        chk("idle_read_same_cycle", 32'(in0_read), 32'd1);
        chk("busy_low_at_launch", 32'(busy), 32'd0);
        c0 = cyc;
        @(negedge clk);
        chk("busy_next_cycle", 32'(busy), 32'd1);
        chk("grant_port0", 32'(grant), 32'd0);
        finish_batch("frame3", 200);
        chk("frame3_writes", wr_cnt, 5);
        if (wr_cyc_q.size() == 5) begin
            chk("first_payload_cycle", wr_cyc_q[2] - c0, 7);
            chk("last_payload_cycle", wr_cyc_q[4] - c0, 9);
        end
        chk("frame_done_cycle", last_ev_cyc - c0, 10);

        // Both ports hold a two-byte frame; port 1 is due after serving port 0.
        load_frame(0, 2, 1'b0);
        load_frame(1, 2, 1'b0);
        start_batch();
        finish_batch("tie", 200);

        // Zero-length frame.
        load_frame(1, 0, 1'b0);
        start_batch();
        finish_batch("zero_len", 100);
        chk("zero_len_writes", wr_cnt, 2);

        // Oversize frame is read out and discarded.
        load_frame(1, 16'h05FF, 1'b0);
        start_batch();
        finish_batch("oversize", 3000);
        chk("oversize_writes", wr_cnt, 0);
        chk("oversize_in1_empty", 32'(in1_empty), 32'd1);
        chk("oversize_q1_empty", q1.size(), 0);

        // Length boundary: exactly MAX_LEN is forwarded, one more is dropped.
        load_frame(0, MAX_LEN, 1'b0);
        load_frame(1, MAX_LEN + 1, 1'b0);
        start_batch();
        finish_batch("boundary", 5000);
        chk("boundary_writes", wr_cnt, MAX_LEN + 2);

        // Five-cycle egress backpressure mid-payload.
        load_frame(0, 12, 1'b0);
        start_batch();
        k = 0;
        while (wr_cnt < 5 && k < 60) begin @(posedge clk); #1; k++; end
        chk("bp_reached_payload", 32'(wr_cnt >= 5), 32'd1);
        out_full = 1'b1;
        w0 = wr_cnt;
        repeat (5) begin @(posedge clk); #1; end
        chk("bp_hold_no_writes", wr_cnt - w0, 0);
        out_full = 1'b0;
        finish_batch("bp", 200);
        chk("bp_writes", wr_cnt, 14);

        // Random frame mixes with random backpressure.
        for (int b = 0; b < 6; b++) begin
            bp_rand = (b % 2) == 1;
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 + n1 == 0) n0 = 1;
            for (int j = 0; j < n0 + n1; j++) begin
                load_frame((j < n0) ? 0 : 1,
                           ($urandom_range(0, 9) == 0) ? MAX_LEN + $urandom_range(1, 6)
                                                       : $urandom_range(0, 24),
                           1'b0);
            end
            start_batch();
            finish_batch("random", 12000);
        end
        bp_rand = 0;

        // Reset in the middle of FWD, then a fresh tie goes to port 0 first.
        load_frame(0, 40, 1'b0);
        start_batch();
        k = 0;
        while (wr_cnt < 8 && k < 100) begin @(posedge clk); #1; k++; end
        chk("mid_fwd_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", {in0_read, in1_read, out_write, grant, busy, frame_done, frame_drop},
            7'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_counters", {fwd_cnt0, fwd_cnt1}, 32'd0);
        chk("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
        q0.delete(); q1.delete(); m0.delete(); m1.delete();
        lens0.delete(); lens1.delete();
        exp_q.delete(); exp_ev_q.delete();
        m_last = 1;
        e_fwd0 = 0; e_fwd1 = 0; e_drop = 0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_frame(0, 2, 1'b0);
        load_frame(1, 2, 1'b0);
        start_batch();
        finish_batch("post_reset", 200);
        chk("post_reset_writes", wr_cnt, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
